// File: rtl/mem_dbus_pkg.sv
// mem_dbus shared definitions
// aluop codes, bus widths, stall levels and FSM encodings
package mem_dbus_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

endpackage

// File: rtl/mem_dbus_if.sv
// Data bus: registered request, acknowledge with read data
// master = memory stage, slave = memory system
interface mem_dbus_if;
  import mem_dbus_pkg::*;

  logic              req;
  logic              we;
  logic [RegBus-1:0] addr;
  logic [3:0]        sel;
  logic [RegBus-1:0] wdata;
  logic              ack;
  logic [RegBus-1:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane steering for the memory stage:
// op decode, byte select, store replication, load extract/extend
module mem_lane_align
  import mem_dbus_pkg::*;
(
  input  logic [7:0]        aluop,
  input  logic [1:0]        addr_lo,
  input  logic [RegBus-1:0] reg2,
  input  logic [RegBus-1:0] rdata,
  output logic              is_mem,
  output logic              is_load,
  output logic              misaligned,
  output logic [3:0]        sel,
  output logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] ldata
);

  size_e       size;
  logic        sext;
  logic        is_store;
  logic        mis_raw;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_W;
    unique case (aluop)
      EXE_LB_OP: begin
        is_load = 1'b1;
        sext    = 1'b1;
        size    = SZ_B;
      end
      EXE_LBU_OP: begin
        is_load = 1'b1;
        size    = SZ_B;
      end
      EXE_LH_OP: begin
        is_load = 1'b1;
        sext    = 1'b1;
        size    = SZ_H;
      end
      EXE_LHU_OP: begin
        is_load = 1'b1;
        size    = SZ_H;
      end
      EXE_LW_OP: is_load = 1'b1;
      EXE_SB_OP: begin
        is_store = 1'b1;
        size     = SZ_B;
      end
      EXE_SH_OP: begin
        is_store = 1'b1;
        size     = SZ_H;
      end
      EXE_SW_OP: is_store = 1'b1;
      default: ;
    endcase
  end

  // lane 0 (addr 00) is the most significant byte
  assign b = rdata[{~addr_lo, 3'b000} +: 8];
  assign h = rdata[{~addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    mis_raw = 1'b0;
    sel     = 4'b1111;
    wdata   = reg2;
    ldata   = rdata;
    unique case (1'b1)
      (size == SZ_B): begin
        sel   = 4'b1000 >> addr_lo;
        wdata = {4{reg2[7:0]}};
        ldata = {{24{sext & b[7]}}, b};
      end
      (size == SZ_H): begin
        mis_raw = addr_lo[0];
        sel     = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata   = {2{reg2[15:0]}};
        ldata   = {{16{sext & h[15]}}, h};
      end
      default: mis_raw = |addr_lo;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = is_mem & mis_raw;

endmodule

// File: rtl/mem_dbus.sv
// Memory-access stage: passes ALU ops through, runs one
// bus transaction per load/store and holds the result for MEM/WB
module mem_dbus
  import mem_dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [7:0]            mem_aluop,
  input  logic [RegBus-1:0]     mem_mem_addr,
  input  logic [RegBus-1:0]     mem_reg2,
  input  logic                  stall_wb,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic                  stallreq,
  output logic                  excp_ade,
  output logic                  bus_err,
  mem_dbus_if.master            dbus
);

  localparam logic [TIMEOUT_W-1:0] LastCnt =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e                state;
  logic [TIMEOUT_W-1:0]  cnt;
  logic [RegBus-1:0]     result;
  logic                  timed_out;
  logic                  is_mem;
  logic                  is_load;
  logic                  mis;
  logic                  issue;
  logic [3:0]            sel;
  logic [RegBus-1:0]     wdata;
  logic [RegBus-1:0]     ldata;

  mem_lane_align u_align (
    .aluop      (mem_aluop),
    .addr_lo    (mem_mem_addr[1:0]),
    .reg2       (mem_reg2),
    .rdata      (dbus.rdata),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .misaligned (mis),
    .sel        (sel),
    .wdata      (wdata),
    .ldata      (ldata)
  );

  assign issue = is_mem & ~mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      result     <= '0;
      timed_out  <= 1'b0;
      bus_err    <= 1'b0;
      dbus.req   <= 1'b0;
      dbus.we    <= 1'b0;
      dbus.addr  <= '0;
      dbus.sel   <= '0;
      dbus.wdata <= '0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        IDLE: if (issue) begin
          state      <= WAIT;
          cnt        <= '0;
          timed_out  <= 1'b0;
          dbus.req   <= 1'b1;
          dbus.we    <= ~is_load;
          dbus.addr  <= {mem_mem_addr[RegBus-1:2], 2'b00};
          dbus.sel   <= sel;
          dbus.wdata <= is_load ? '0 : wdata;
        end
        WAIT: begin
          cnt <= cnt + TIMEOUT_W'(1);
          if (dbus.ack) begin
            state    <= DONE;
            result   <= is_load ? ldata : '0;
            dbus.req <= 1'b0;
            dbus.we  <= 1'b0;
          end else if (cnt == LastCnt) begin
            state     <= DONE;
            result    <= '0;
            timed_out <= 1'b1;
            bus_err   <= 1'b1;
            dbus.req  <= 1'b0;
            dbus.we   <= 1'b0;
          end
        end
        DONE: if (stall_wb == NoStop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_wd    = '0;
    wb_wreg  = 1'b0;
    wb_wdata = '0;
    stallreq = 1'b0;
    excp_ade = mis;
    if (rst) begin
      wb_wd = mem_wd;
      unique case (state)
        IDLE: begin
          if (!is_mem) begin
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end
          stallreq = issue;
        end
        WAIT: stallreq = 1'b1;
        DONE: begin
          wb_wreg  = mem_wreg & is_load & ~timed_out;
          wb_wdata = result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus.sv
// Scoreboard bench for mem_dbus: directed ops, bus responder,
// writeback and bus-request monitors
module tb_mem_dbus;
  import mem_dbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic        stall_wb;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        excp_ade;
  logic        bus_err;

  mem_dbus_if dbus ();

  mem_dbus #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .stall_wb     (stall_wb),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .stallreq     (stallreq),
    .excp_ade     (excp_ade),
    .bus_err      (bus_err),
    .dbus         (dbus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          tx_count = 0;
  int          err_pulses = 0;
  int          ack_delay = 0;
  logic [31:0] rdata_v = '0;
  logic        force_ack = 1'b0;
  logic        tb_valid = 1'b0;
  logic [37:0] cap_q[$];
  logic [68:0] bus_q[$];

  task automatic check(input string nm,
                       input logic [71:0] act,
                       input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic nop();
    mem_aluop    = 8'h00;
    mem_wd       = 5'd0;
    mem_wreg     = 1'b0;
    mem_wdata    = '0;
    mem_mem_addr = '0;
    mem_reg2     = '0;
  endtask

  // bus responder: ack in the Nth WAIT cycle, 0 = never
  initial begin
    int wcnt;
    wcnt = 0;
    dbus.ack   = 1'b0;
    dbus.rdata = '0;
    forever begin
      @(negedge clk);
      if (dbus.req) wcnt++;
      else wcnt = 0;
      dbus.ack = force_ack |
        (dbus.req && ack_delay != 0 && wcnt == ack_delay);
      dbus.rdata = rdata_v;
    end
  end

  // writeback monitor: MEM/WB captures when not stalled
  initial forever begin
    @(negedge clk);
    if (rst && tb_valid && !stallreq && stall_wb == NoStop) begin
      if (cap_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got %h, want none",
                 {wb_wd, wb_wreg, wb_wdata});
      end else begin
        check("wb", 72'({wb_wd, wb_wreg, wb_wdata}),
              72'(cap_q.pop_front()));
      end
    end
  end

  // bus monitor: one compare per request rising edge
  initial begin
    logic req_q;
    req_q = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_err) err_pulses++;
      if (dbus.req && !req_q) begin
        tx_count++;
        if (bus_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL bus_unexpected: got addr %h, want none",
                   dbus.addr);
        end else begin
          check("bus_req",
                72'({dbus.we, dbus.addr, dbus.sel, dbus.wdata}),
                72'(bus_q.pop_front()));
        end
      end
      req_q = dbus.req;
    end
  end

  task automatic run_op(input logic [7:0]  op,
                        input logic [4:0]  wd,
                        input logic        wreg,
                        input logic [31:0] wdata,
                        input logic [31:0] addr,
                        input logic [31:0] reg2,
                        input logic [31:0] rdata,
                        input int          delay,
                        input int          stops,
                        input logic        exp_ade,
                        input logic [37:0] exp_wb,
                        input int          exp_stall);
    int st;
    int left;
    bit done;
    st   = 0;
    left = stops;
    done = 1'b0;
    cap_q.push_back(exp_wb);
    ack_delay    = delay;
    rdata_v      = rdata;
    mem_aluop    = op;
    mem_wd       = wd;
    mem_wreg     = wreg;
    mem_wdata    = wdata;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    stall_wb     = (left > 0);
    tb_valid     = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) check("excp_ade", 72'(excp_ade), 72'(exp_ade));
      if (stallreq) st++;
      else if (stall_wb == Stop) begin
        check("hold", 72'(wb_wdata), 72'(exp_wb[31:0]));
        left--;
      end else begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      stall_wb = (left > 0);
    end
    check("retired", 72'(done), 72'(1));
    check("stall_cycles", 72'(st), 72'(exp_stall));
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    stall_wb = NoStop;
    nop();
  endtask

  initial begin
    int t0;
    int e0;
    stall_wb     = NoStop;
    mem_aluop    = 8'h00;
    mem_wd       = 5'd2;
    mem_wreg     = 1'b1;
    mem_wdata    = 32'h55;
    mem_mem_addr = '0;
    mem_reg2     = '0;

    @(negedge clk);
    check("rst_wb", 72'({wb_wd, wb_wreg, wb_wdata}), 72'(0));
    check("rst_bus", 72'({dbus.req, dbus.we, dbus.addr}), 72'(0));
    check("rst_err", 72'(bus_err), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    nop();
    @(posedge clk);
    #1;

    t0 = tx_count;
    run_op(8'b0010_0101, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0,
           32'h0, 1, 0, 1'b0, {5'd3, 1'b1, 32'h1234}, 0);
    check("alu_no_bus", 72'(tx_count - t0), 72'(0));

    bus_q.push_back({1'b0, 32'h100, 4'b0100, 32'h0});
    run_op(EXE_LB_OP, 5'd5, 1'b1, 32'h0, 32'h101, 32'h0,
           32'h11F2_3344, 1, 0, 1'b0,
           {5'd5, 1'b1, 32'hFFFF_FFF2}, 2);

    bus_q.push_back({1'b1, 32'h200, 4'b0011, 32'h1234_1234});
    run_op(EXE_SH_OP, 5'd7, 1'b1, 32'h0, 32'h202, 32'hABCD_1234,
           32'h0, 3, 0, 1'b0, {5'd7, 1'b0, 32'h0}, 4);

    t0 = tx_count;
    run_op(EXE_LW_OP, 5'd9, 1'b1, 32'h0, 32'h3, 32'h0,
           32'h0, 1, 0, 1'b1, {5'd9, 1'b0, 32'h0}, 0);
    check("ade_no_bus", 72'(tx_count - t0), 72'(0));

    e0 = err_pulses;
    bus_q.push_back({1'b0, 32'h400, 4'b1111, 32'h0});
    run_op(EXE_LW_OP, 5'd10, 1'b1, 32'h0, 32'h400, 32'h0,
           32'hFFFF_FFFF, 0, 0, 1'b0, {5'd10, 1'b0, 32'h0}, 17);
    check("bus_err_pulse", 72'(err_pulses - e0), 72'(1));

    t0 = tx_count;
    bus_q.push_back({1'b0, 32'h108, 4'b0011, 32'h0});
    run_op(EXE_LHU_OP, 5'd11, 1'b1, 32'h0, 32'h10A, 32'h0,
           32'h7FFF_9ABC, 1, 3, 1'b0,
           {5'd11, 1'b1, 32'h0000_9ABC}, 2);
    check("stop_single_tx", 72'(tx_count - t0), 72'(1));

    bus_q.push_back({1'b0, 32'h700, 4'b1100, 32'h0});
    run_op(EXE_LH_OP, 5'd12, 1'b1, 32'h0, 32'h700, 32'h0,
           32'h8001_2222, 2, 0, 1'b0,
           {5'd12, 1'b1, 32'hFFFF_8001}, 3);

    // reset while the bus access is outstanding
    e0 = err_pulses;
    ack_delay = 0;
    bus_q.push_back({1'b0, 32'h500, 4'b1111, 32'h0});
    mem_aluop    = EXE_LW_OP;
    mem_wd       = 5'd15;
    mem_wreg     = 1'b1;
    mem_mem_addr = 32'h500;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b0;
    mem_aluop    = 8'h00;
    mem_wd       = 5'd1;
    mem_wreg     = 1'b1;
    mem_wdata    = 32'hCAFE;
    mem_mem_addr = '0;
    @(negedge clk);
    check("rst_mid_req", 72'(dbus.req), 72'(0));
    check("rst_mid_stall", 72'(stallreq), 72'(0));
    check("rst_mid_wb", 72'({wb_wd, wb_wreg, wb_wdata}), 72'(0));
    @(posedge clk);
    #1;
    rst       = 1'b1;
    force_ack = 1'b1;
    t0        = tx_count;
    repeat (2) begin
      @(negedge clk);
      check("late_ack_req", 72'(dbus.req), 72'(0));
      check("late_ack_idle", 72'({wb_wd, wb_wreg, wb_wdata}),
            72'({5'd1, 1'b1, 32'hCAFE}));
    end
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    nop();
    check("late_ack_no_tx", 72'(tx_count - t0), 72'(0));
    check("rst_no_err", 72'(err_pulses - e0), 72'(0));
    @(posedge clk);
    #1;

    bus_q.push_back({1'b1, 32'h600, 4'b0001, 32'h5A5A_5A5A});
    run_op(EXE_SB_OP, 5'd13, 1'b1, 32'h0, 32'h603, 32'h1234_565A,
           32'h0, 1, 0, 1'b0, {5'd13, 1'b0, 32'h0}, 2);

    bus_q.push_back({1'b1, 32'h800, 4'b1111, 32'hDEAD_BEEF});
    run_op(EXE_SW_OP, 5'd14, 1'b1, 32'h0, 32'h800, 32'hDEAD_BEEF,
           32'h0, 2, 0, 1'b0, {5'd14, 1'b0, 32'h0}, 3);

    repeat (2) @(negedge clk);
    check("cap_q_empty", 72'(cap_q.size()), 72'(0));
    check("bus_q_empty", 72'(bus_q.size()), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_dbus.md
Name: mem_dbus

Overview:
- Memory-access stage; sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Non-memory instructions pass through combinationally.
- Loads and stores issue one registered request/acknowledge transaction on the data bus. The stage raises a stall request to the pipeline controller until the access completes.
- The completed result is held until MEM/WB captures it.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of WAIT cycles without dbus_ack before the access is aborted with bus_err.
- TIMEOUT_W, 5: counter width. Must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_wd  in  5  destination register address from EX/MEM.
- mem_wreg  in  1  register write enable from EX/MEM.
- mem_wdata  in  32  ALU result from EX/MEM.
- mem_aluop  in  8  operation code from EX/MEM.
- mem_mem_addr  in  32  effective address.
- mem_reg2  in  32  store data (rt).
- stall_wb  in  1  stall[4] from the pipeline controller; Stop means MEM/WB does not capture this cycle.
- wb_wd  out  5  destination register address to MEM/WB.
- wb_wreg  out  1  register write enable to MEM/WB.
- wb_wdata  out  32  result data to MEM/WB.
- stallreq  out  1  stall request to the pipeline controller.
- excp_ade  out  1  address-alignment error, combinational.
- bus_err  out  1  one-cycle pulse on access timeout.
- dbus_req  out  1  registered bus request.
- dbus_we  out  1  registered write strobe.
- dbus_addr  out  32  registered word address, bits [1:0] = 0.
- dbus_sel  out  4  registered byte-lane select; bit 3 = byte lane 31:24.
- dbus_wdata  out  32  registered write data.
- dbus_ack  in  1  bus acknowledge.
- dbus_rdata  in  32  bus read data, valid when dbus_ack = 1.

Behaviour:

Operation classification:
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Alignment rules: halfword ops require addr[0] = 0; word ops require addr[1:0] = 0.
- Misaligned op: excp_ade = 1, no bus request, wb_wreg = 0, stallreq = 0.

Byte order is big-endian:
- Byte lanes: addr[1:0] = 00 selects rdata[31:24] and dbus_sel = 1000; 11 selects [7:0] and 0001.
- Halfword lanes: addr[1] = 0 selects [31:16] and sel 1100; addr[1] = 1 selects [15:0] and sel 0011.
- Word access: sel 1111.
- Store data is replicated across lanes: SB gives {4{b}}; SH gives {2{h}}.
- Load extension: LB and LH sign-extend; LBU and LHU zero-extend.

FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Non-memory op: wb_* = mem_*, stallreq = 0.
  - Aligned memory op: stallreq = 1. Next edge registers the dbus_* outputs, sets dbus_req = 1 and moves to WAIT.
- WAIT:
  - dbus_req, dbus_* and stallreq are held stable.
  - The timeout counter increments each cycle.
  - dbus_ack = 1: capture the extended load data (stores capture 0) into the result register, drop dbus_req, go to DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: drop dbus_req, capture 0, pulse bus_err, go to DONE.
- DONE:
  - stallreq = 0.
  - wb_wd = mem_wd; wb_wreg = mem_wreg for loads and 0 for stores; loads also drop wb_wreg on timeout; wb_wdata = result register.
  - stall_wb = Stop: stay in DONE, no re-issue.
  - stall_wb = NoStop: go to IDLE; the next instruction is evaluated in the following cycle.

Latency:
- Minimum: op visible in cycle 0, dbus_req high in cycle 1, ack in cycle 1, DONE in cycle 2, MEM/WB captures at the end of cycle 2.
- stallreq is high in cycles 0 and 1.

Other rules:
- dbus_ack outside WAIT is ignored.
- rst low at any time: state IDLE, dbus_req/dbus_we = 0, dbus_addr/dbus_sel/dbus_wdata = 0, bus_err = 0, counter = 0, result = 0.
  - wb_wd = 0, wb_wreg = 0, wb_wdata = 0 while rst is low.
  - An access in flight is abandoned, with no further dbus_req.

Decomposition:
- Shared defines: aluop codes EXE_LB_OP … EXE_SW_OP, RegBus/RegAddrBus widths, Stop/NoStop, and the FSM state encodings (2 bits).
- One sub-module, mem_lane_align (combinational): sel/wdata generation, load extraction, sign extension, misalignment detection.

Test Plan:
- Non-memory op with wd = 3 and wdata = 0x1234 -> wb_wdata = 0x1234 in the same cycle; stallreq = 0; dbus_req never asserted.
- LB at addr 0x101, rdata = 0x11F233 44, ack in cycle 1 -> dbus_addr = 0x100, sel = 0100; wb_wdata = 0xFFFFFFF2 in cycle 2; stallreq high in cycles 0–1.
- SH at addr 0x202, reg2 = 0xABCD1234, ack after 3 WAIT cycles -> sel = 0011, wdata = 0x12341234, dbus_we = 1; wb_wreg = 0; stallreq high 4 cycles.
- LW at addr 0x3, no request -> excp_ade = 1; dbus_req = 0.
- LW with no ack -> after 16 WAIT cycles bus_err pulses; wb_wdata = 0; wb_wreg = 0.
- Ack arrives while stall_wb = Stop for 3 cycles -> state holds DONE with a stable result; single bus transaction.
- rst low mid-WAIT -> dbus_req = 0 and IDLE; a late ack is ignored.
